hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Parametrised HI/LO register pair with an integrated iterative multiply/divide engine for the execute stage.
- Holds the MIPS HI/LO state.
- Accepts direct HI/LO writes (MTHI/MTLO path) and multi-cycle MULT/MULTU/DIV/DIVU operations.
- Reports busy so the pipeline stalls; commits both halves atomically on completion.

Parameters:
- DATA_W, 32, width of each operand and of HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- cpu_clk_50M  in  1  single clock.
- cpu_rst  in  1  synchronous, active-high reset.
- start_i  in  1  launch operation; sampled only in IDLE.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a_i  in  DATA_W  multiplicand/dividend.
- src_b_i  in  DATA_W  multiplier/divisor.
- flush_i  in  1  abort in-flight operation.
- we_hi_i  in  1  direct HI write.
- we_lo_i  in  1  direct LO write.
- hi_i  in  DATA_W  direct HI data.
- lo_i  in  DATA_W  direct LO data.
- busy_o  out  1  engine not IDLE.
- done_o  out  1  one-cycle pulse in the commit cycle.
- hi_o  out  DATA_W  HI contents.
- lo_o  out  DATA_W  LO contents.

Behaviour:
- Clock and reset:
  - One clock: cpu_clk_50M.
  - Reset cpu_rst is synchronous and active-high.
  - On reset: hi_o=0, lo_o=0, busy_o=0, done_o=0, state=IDLE, counter=0.
  - Reset in the middle of an operation discards it; no commit occurs.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start_i=1 latches operands and op.
  - Next state is MUL (op 0x) or DIV (op 1x), with counter=0.
  - start_i in any other state is ignored.
  - The core must hold the request while busy_o=1.
- MUL:
  - Radix-2 shift-add on the operand magnitudes into a 2*DATA_W accumulator.
  - One bit per cycle, DATA_W cycles, then FIX.
- DIV:
  - Radix-2 restoring division on the magnitudes.
  - One quotient bit per cycle, DATA_W cycles, then FIX.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitudes at latch time; the signs are saved.
  - MULT: product is negated if the signs differ.
  - DIV: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Most-negative operands are handled correctly because magnitudes are held unsigned in DATA_W bits.
- FIX (one cycle):
  - Sign correction; done_o=1.
  - At the end of this cycle HI/LO are written together.
  - MUL: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV: LO=quotient, HI=remainder.
  - Next state is IDLE.
- Latency:
  - start_i sampled at edge k; new HI/LO visible after edge k+DATA_W+2 (34 edges for DATA_W=32).
  - busy_o is high from edge k+1 through the FIX cycle inclusive.
- Divide by zero (divisor=0): no trap.
  - LO = all ones.
  - HI = dividend, with the sign rule applied (equal to src_a_i).
  - Full DATA_W+2 latency.
- Direct writes:
  - we_hi_i/we_lo_i are honoured only when busy_o=0; ignored while busy.
  - Both may be asserted in the same cycle; each half updates independently.
  - Direct write and start_i in the same IDLE cycle: the direct write takes effect now; the operation later overwrites both halves.
- Flush:
  - flush_i=1 in MUL/DIV/FIX returns to IDLE next cycle.
  - No HI/LO change; done_o suppressed.
  - In IDLE, flush_i is ignored and does not block a simultaneous start_i.
- Priority: cpu_rst > flush_i > commit > direct write.

Optional Feature:
- Macro HILO_FWD_EN.
- Defined: hi_o/lo_o are combinationally forwarded from the pending write in the same cycle.
  - Commit value during FIX when flush_i=0.
  - Direct-write value when the write is honoured.
  - Lets MFHI/MFLO read without a stall cycle.
- Undefined: hi_o/lo_o are pure register outputs; new values appear the cycle after the write.

Decomposition:
- Shared package:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State encodings.
  - DATA_W default, aligned with the existing REG_BUS width.
- Sub-module div_core: the iterative restoring divider with start/done.
  - The shift-add multiplier stays inline in hilo_muldiv.

Test Plan (DATA_W=32):
- Reset, then MULT -3 × 5 -> busy_o rises next edge; done_o after 33 edges; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100 / 7 -> LO=14, HI=2; MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, no done_o suppression.
- Start MULT, assert flush_i at iteration 10, plus we_hi_i=1 with hi_i=0x1234 while busy -> HI/LO keep prior values, no done_o; MTHI 0x1234 after idle -> HI=0x1234, LO unchanged.
- Reset mid-DIV -> all outputs 0 after the edge, no commit; with HILO_FWD_EN, hi_o equals the new value during FIX and during a direct-write cycle.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO register pair and its multiply/divide engine.
// Operation and state encodings plus the default datapath width.
package hilo_muldiv_pkg;

    localparam int REG_BUS_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

    // Bit 0 clear means the signed flavour (MULT, DIV).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done pulses in the cycle that computes the last bit; results hold until the next start.
module div_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              fits;

    // A zero divisor always "fits", yielding an all-ones quotient and remainder = dividend.
    assign shifted = {remainder, quotient[DATA_W-1]};
    assign fits    = shifted >= {1'b0, dvsr};
    assign trial   = shifted - {1'b0, dvsr};
    assign done    = running && (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            running   <= 1'b0;
            cnt       <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running   <= 1'b1;
            cnt       <= '0;
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (running) begin
            cnt       <= cnt + CNT_W'(1);
            remainder <= fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
            quotient  <= {quotient[DATA_W-2:0], fits};
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU engine (IDLE->MUL|DIV->FIX->IDLE).
// Define HILO_FWD_EN to forward pending HI/LO writes combinationally onto hi_o/lo_o.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int CNT_W  = 6
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    input  logic              we_hi_i,
    input  logic              we_lo_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                is_div, sign_a, sign_b, div_zero;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic                idle, start_ok, last_mul, commit, div_done;
    logic                sa, sb;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   quot, rem;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix, res_hi, res_lo;
    logic                hi_we, lo_we;
    logic [DATA_W-1:0]   hi_nxt, lo_nxt;

    assign idle     = (state == ST_IDLE);
    assign start_ok = idle && start_i;
    assign last_mul = (cnt == CNT_W'(DATA_W - 1));
    assign commit   = (state == ST_FIX) && !flush_i;
    assign busy_o   = !idle;
    assign done_o   = commit;

    // Magnitudes fit unsigned in DATA_W bits, so the most-negative operand needs no special case.
    always_comb begin
        sa    = op_is_signed(op_i) & src_a_i[DATA_W-1];
        sb    = op_is_signed(op_i) & src_b_i[DATA_W-1];
        mag_a = sa ? -src_a_i : src_a_i;
        mag_b = sb ? -src_b_i : src_b_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = op_i[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (flush_i) state_nxt = ST_IDLE; else if (last_mul) state_nxt = ST_FIX;
            ST_DIV:  if (flush_i) state_nxt = ST_IDLE; else if (div_done) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                cnt      <= '0;
                is_div   <= op_i[1];
                sign_a   <= sa;
                sign_b   <= sb;
                div_zero <= (src_b_i == '0);
                mcand    <= mag_a;
                prod     <= {{DATA_W{1'b0}}, mag_b};
            end else if (state == ST_MUL || state == ST_DIV) begin
                cnt <= cnt + CNT_W'(1);
                if (state == ST_MUL) begin
                    prod <= {mul_sum, prod[DATA_W-1:1]};
                end
            end
        end
    end

    div_core #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_div_core (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst    (cpu_rst),
        .start      (start_ok && op_i[1]),
        .abort      (flush_i && !idle),
        .dividend   (mag_a),
        .divisor    (mag_b),
        .done       (div_done),
        .quotient   (quot),
        .remainder  (rem)
    );

    // Divide-by-zero keeps the raw all-ones quotient; the remainder still follows the dividend.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix = ((sign_a ^ sign_b) && !div_zero) ? -quot : quot;
        rem_fix  = sign_a ? -rem : rem;
        res_hi   = is_div ? rem_fix  : prod_fix[2*DATA_W-1:DATA_W];
        res_lo   = is_div ? quot_fix : prod_fix[DATA_W-1:0];
        hi_we    = commit || (idle && we_hi_i);
        lo_we    = commit || (idle && we_lo_i);
        hi_nxt   = commit ? res_hi : hi_i;
        lo_nxt   = commit ? res_lo : lo_i;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_nxt;
            if (lo_we) lo_q <= lo_nxt;
        end
    end

`ifdef HILO_FWD_EN
    assign hi_o = hi_we ? hi_nxt : hi_q;
    assign lo_o = lo_we ? lo_nxt : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule
